wb_retire_queue: RTL

- Consumer end of the MEM/WB pipeline register for the dual-lane core.
- Accepts up to two 71-bit MEM/WB bundles per cycle (lane0 older than lane1) and resolves each to a (rd, data) write.
- Buffers the writes in an in-order circular queue and drains one per cycle into the single register-file write port.
- Optionally provides a forwarding lookup so ID/EX can read queued-but-unretired results.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/memwb_unpack.sv | 24 ++
 rtl/wb_retire_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared MEM/WB bundle layout and retire-queue entry format.
package wb_pkg;

  localparam int BUNDLE_W    = 71;
  localparam int REGWR_BIT   = 70;
  localparam int MEM2REG_BIT = 69;
  localparam int RD_HI       = 68;
  localparam int RD_LO       = 64;
  localparam int MEMDATA_HI  = 63;
  localparam int MEMDATA_LO  = 32;
  localparam int ALU_HI      = 31;
  localparam int ALU_LO      = 0;

  localparam int RD_W    = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = 37;

  // Entry packs {rd, data}
  localparam int E_RD_HI = ENTRY_W - 1;
  localparam int E_RD_LO = DATA_W;

endpackage

// File: rtl/memwb_unpack.sv
// Splits one MEM/WB bundle into rd, resolved write data and a
// qualify flag (reg_write with a non-zero destination).
module memwb_unpack
  import wb_pkg::*;
(
  input  logic [BUNDLE_W-1:0] bundle,
  output logic                qual,
  output logic [RD_W-1:0]     rd,
  output logic [DATA_W-1:0]   data
);

  logic reg_write;
  logic mem_to_reg;

  assign reg_write  = bundle[REGWR_BIT];
  assign mem_to_reg = bundle[MEM2REG_BIT];
  assign rd         = bundle[RD_HI:RD_LO];

  assign data = mem_to_reg ? bundle[MEMDATA_HI:MEMDATA_LO]
                           : bundle[ALU_HI:ALU_LO];

  assign qual = reg_write && (rd != '0);

endmodule

// File: rtl/wb_retire_queue.sv
// Dual-lane MEM/WB retire queue draining into one RF write port.
// Optional forwarding lookup enabled by WB_RETIRE_FWD_EN.
module wb_retire_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                lane0_valid,
  input  logic [BUNDLE_W-1:0] lane0_bundle,
  input  logic                lane1_valid,
  input  logic [BUNDLE_W-1:0] lane1_bundle,
  output logic                in_ready,
  output logic                rf_we,
  output logic [RD_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [PTR_W:0]      count,
  input  logic [RD_W-1:0]     fwd_raddr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data
);

  localparam logic [PTR_W:0] CNT_LIM = (PTR_W+1)'(DEPTH - 2);

  logic               l0_qual;
  logic [RD_W-1:0]    l0_rd;
  logic [DATA_W-1:0]  l0_data;
  logic               l1_qual;
  logic [RD_W-1:0]    l1_rd;
  logic [DATA_W-1:0]  l1_data;

  memwb_unpack u_unpack0 (
    .bundle (lane0_bundle),
    .qual   (l0_qual),
    .rd     (l0_rd),
    .data   (l0_data)
  );

  memwb_unpack u_unpack1 (
    .bundle (lane1_bundle),
    .qual   (l1_qual),
    .rd     (l1_rd),
    .data   (l1_data)
  );

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W:0]     count_q;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic             acc0;
  logic             acc1;
  logic             pop;
  logic [PTR_W-1:0] wr1_idx;
  logic [ENTRY_W-1:0] head_e;

  assign in_ready = (count_q <= CNT_LIM);
  assign acc0     = lane0_valid && l0_qual && in_ready;
  assign acc1     = lane1_valid && l1_qual && in_ready;
  assign pop      = (count_q != '0);
  // lane1 lands right after lane0 only if lane0 took a slot
  assign wr1_idx  = tail + PTR_W'(acc0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(pop);
      tail    <= tail + PTR_W'(acc0) + PTR_W'(acc1);
      count_q <= count_q + (PTR_W+1)'(acc0)
               + (PTR_W+1)'(acc1) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (acc0) mem[tail]    <= {l0_rd, l0_data};
      if (acc1) mem[wr1_idx] <= {l1_rd, l1_data};
    end
  end

  assign head_e   = mem[head];
  assign count    = count_q;
  assign rf_we    = pop;
  assign rf_waddr = pop ? head_e[E_RD_HI:E_RD_LO] : '0;
  assign rf_wdata = pop ? head_e[DATA_W-1:0] : '0;

`ifdef WB_RETIRE_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) &&
          (fwd_raddr != '0) &&
          (mem[fwd_idx][E_RD_HI:E_RD_LO] == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem[fwd_idx][DATA_W-1:0];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^fwd_raddr;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
